// File: rtl/meas_cmd_sched_if.sv
// Command/readback, equivalent-sampling and frequency-meter signals of the command scheduler.
// master: command source and measurement engines; slave: meas_cmd_sched.
interface meas_cmd_sched_if;
    logic [31:0] cmd_in;
    logic        cmd_valid;
    logic [31:0] es_cmd;
    logic        es_cmd_valid;
    logic [31:0] es_data;
    logic        fm_clear;
    logic        fm_gate;
    logic        fm_done;
    logic [31:0] fx_data;
    logic [31:0] fs_data;
    logic [31:0] duty_data;
    logic [31:0] rsp_data;
    logic        busy;

    modport master (
        output cmd_in, cmd_valid, es_data, fm_done, fx_data, fs_data, duty_data,
        input  es_cmd, es_cmd_valid, fm_clear, fm_gate, rsp_data, busy
    );

    modport slave (
        input  cmd_in, cmd_valid, es_data, fm_done, fx_data, fs_data, duty_data,
        output es_cmd, es_cmd_valid, fm_clear, fm_gate, rsp_data, busy
    );
endinterface

// File: rtl/meas_cmd_sched.sv
// Decodes SPI commands, forwards sampling opcodes, sequences the frequency meter
// (clear, gate, wait with timeout) and registers the selected readback word.
module meas_cmd_sched #(
    parameter int unsigned GATE_UNIT_CYC = 50000,
    parameter int unsigned CLR_CYC       = 4,
    parameter int unsigned TIMEOUT_CYC   = 5000000
) (
    input logic             clk,
    input logic             rest,
    meas_cmd_sched_if.slave bus
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StClr  = 3'd1;
    localparam logic [2:0] StGate = 3'd2;
    localparam logic [2:0] StWait = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    localparam logic [2:0] SelStatus = 3'd0;
    localparam logic [2:0] SelEs     = 3'd1;
    localparam logic [2:0] SelFx     = 3'd2;
    localparam logic [2:0] SelFs     = 3'd3;
    localparam logic [2:0] SelDuty   = 3'd4;

    localparam logic [31:0] ClrLast  = 32'(CLR_CYC - 1);
    localparam logic [31:0] GateLast = 32'(GATE_UNIT_CYC - 1);
    localparam logic [31:0] TmoLast  = 32'(TIMEOUT_CYC - 1);

    logic [2:0]  state_q, state_d;
    logic [2:0]  rsp_sel_q, rsp_sel_d;
    logic [31:0] es_cmd_q, es_cmd_d;
    logic        es_cmd_valid_q, es_cmd_valid_d;
    logic        fm_clear_q, fm_clear_d;
    logic        fm_gate_q, fm_gate_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] presc_q, presc_d;
    logic [23:0] unit_q, unit_d;
    logic [23:0] gate_n_q, gate_n_d;
    logic [31:0] fx_q, fx_d;
    logic [31:0] fs_q, fs_d;
    logic [31:0] duty_q, duty_d;
    logic [15:0] meas_cnt_q, meas_cnt_d;
    logic        done_flag_q, done_flag_d;
    logic        err_busy_q, err_busy_d;
    logic        err_illegal_q, err_illegal_d;
    logic        err_timeout_q, err_timeout_d;
    logic        busy;
    logic [3:0]  opcode;

    assign busy   = (state_q != StIdle);
    assign opcode = bus.cmd_in[31:28];

    always_comb begin
        state_d        = state_q;
        rsp_sel_d      = rsp_sel_q;
        es_cmd_d       = es_cmd_q;
        es_cmd_valid_d = 1'b0;
        fm_clear_d     = fm_clear_q;
        fm_gate_d      = fm_gate_q;
        cnt_d          = cnt_q;
        presc_d        = presc_q;
        unit_d         = unit_q;
        gate_n_d       = gate_n_q;
        fx_d           = fx_q;
        fs_d           = fs_q;
        duty_d         = duty_q;
        meas_cnt_d     = meas_cnt_q;
        done_flag_d    = done_flag_q;
        err_busy_d     = err_busy_q;
        err_illegal_d  = err_illegal_q;
        err_timeout_d  = err_timeout_q;

        case (state_q)
            StClr: begin
                if (cnt_q == ClrLast) begin
                    state_d    = StGate;
                    fm_clear_d = 1'b0;
                    fm_gate_d  = 1'b1;
                    presc_d    = '0;
                    unit_d     = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StGate: begin
                // Prescaler counts cycles within a unit; unit counter counts whole units.
                if (presc_q == GateLast) begin
                    presc_d = '0;
                    if (unit_q == gate_n_q - 24'd1) begin
                        state_d   = StWait;
                        fm_gate_d = 1'b0;
                        cnt_d     = '0;
                    end else begin
                        unit_d = unit_q + 24'd1;
                    end
                end else begin
                    presc_d = presc_q + 32'd1;
                end
            end
            StWait: begin
                // fm_done beats a timeout expiring in the same cycle.
                if (bus.fm_done) begin
                    state_d     = StDone;
                    fx_d        = bus.fx_data;
                    fs_d        = bus.fs_data;
                    duty_d      = bus.duty_data;
                    done_flag_d = 1'b1;
                    meas_cnt_d  = meas_cnt_q + 16'd1;
                end else if (cnt_q == TmoLast) begin
                    state_d       = StDone;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: ;
        endcase

        if (bus.cmd_valid) begin
            case (opcode)
                4'h1, 4'h2, 4'h3: begin
                    es_cmd_d       = bus.cmd_in;
                    es_cmd_valid_d = 1'b1;
                    rsp_sel_d      = SelEs;
                end
                4'h4: begin
                    if (state_q == StIdle || state_q == StDone) begin
                        state_d     = StClr;
                        fm_clear_d  = 1'b1;
                        fm_gate_d   = 1'b0;
                        cnt_d       = '0;
                        gate_n_d    = (bus.cmd_in[23:0] == 24'd0) ? 24'd1 : bus.cmd_in[23:0];
                        done_flag_d = 1'b0;
                    end else begin
                        err_busy_d = 1'b1;
                    end
                end
                4'h5: rsp_sel_d = SelFx;
                4'h6: rsp_sel_d = SelFs;
                4'h7: rsp_sel_d = SelDuty;
                4'h0: rsp_sel_d = SelStatus;
                4'h8: begin
                    state_d    = StIdle;
                    fm_gate_d  = 1'b0;
                    fm_clear_d = 1'b0;
                end
                4'h9: begin
                    err_busy_d    = 1'b0;
                    err_illegal_d = 1'b0;
                    err_timeout_d = 1'b0;
                end
                default: err_illegal_d = 1'b1;
            endcase
        end

        case (rsp_sel_q)
            SelEs:   rsp_data_d = bus.es_data;
            SelFx:   rsp_data_d = fx_q;
            SelFs:   rsp_data_d = fs_q;
            SelDuty: rsp_data_d = duty_q;
            default: rsp_data_d = {state_q, busy, done_flag_q, err_busy_q, err_illegal_q,
                                   err_timeout_q, 8'd0, meas_cnt_q};
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q        <= StIdle;
            rsp_sel_q      <= SelStatus;
            es_cmd_q       <= '0;
            es_cmd_valid_q <= 1'b0;
            fm_clear_q     <= 1'b0;
            fm_gate_q      <= 1'b0;
            rsp_data_q     <= '0;
            cnt_q          <= '0;
            presc_q        <= '0;
            unit_q         <= '0;
            gate_n_q       <= '0;
            fx_q           <= '0;
            fs_q           <= '0;
            duty_q         <= '0;
            meas_cnt_q     <= '0;
            done_flag_q    <= 1'b0;
            err_busy_q     <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            rsp_sel_q      <= rsp_sel_d;
            es_cmd_q       <= es_cmd_d;
            es_cmd_valid_q <= es_cmd_valid_d;
            fm_clear_q     <= fm_clear_d;
            fm_gate_q      <= fm_gate_d;
            rsp_data_q     <= rsp_data_d;
            cnt_q          <= cnt_d;
            presc_q        <= presc_d;
            unit_q         <= unit_d;
            gate_n_q       <= gate_n_d;
            fx_q           <= fx_d;
            fs_q           <= fs_d;
            duty_q         <= duty_d;
            meas_cnt_q     <= meas_cnt_d;
            done_flag_q    <= done_flag_d;
            err_busy_q     <= err_busy_d;
            err_illegal_q  <= err_illegal_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign bus.es_cmd       = es_cmd_q;
    assign bus.es_cmd_valid = es_cmd_valid_q;
    assign bus.fm_clear     = fm_clear_q;
    assign bus.fm_gate      = fm_gate_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.busy         = busy;

endmodule

// File: tb/tb_meas_cmd_sched.sv
// Self-checking bench for meas_cmd_sched: randomized commands and meter results
// compared with a register-level model of scheduler status.
module tb_meas_cmd_sched;

    localparam int G = 10;
    localparam int C = 4;
    localparam int T = 20;

    logic clk;
    logic rest;
    meas_cmd_sched_if bus ();

    meas_cmd_sched #(
        .GATE_UNIT_CYC (G),
        .CLR_CYC       (C),
        .TIMEOUT_CYC   (T)
    ) dut (
        .clk  (clk),
        .rest (rest),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model of scheduler state
    int          m_state;
    bit          m_done, m_eb, m_ei, m_et;
    logic [15:0] m_cnt;
    logic [31:0] m_fx, m_fs, m_duty;

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        w = (32'(m_state) << 29) | (32'(m_state != 0) << 28) | (32'(m_done) << 27)
          | (32'(m_eb) << 26) | (32'(m_ei) << 25) | (32'(m_et) << 24) | 32'(m_cnt);
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_done = 0; m_eb = 0; m_ei = 0; m_et = 0;
        m_cnt = '0; m_fx = '0; m_fs = '0; m_duty = '0;
    endtask

    task automatic send_cmd(input logic [31:0] c);
        @(negedge clk);
        bus.cmd_in    = c;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic read_sel(input logic [3:0] op, output logic [31:0] v);
        send_cmd({op, 28'h0});
        @(negedge clk);
        v = bus.rsp_data;
    endtask

    task automatic pulse_done(input logic [31:0] fx, input logic [31:0] fs,
                              input logic [31:0] du);
        @(negedge clk);
        bus.fx_data = fx; bus.fs_data = fs; bus.duty_data = du;
        bus.fm_done = 1'b1;
        @(negedge clk);
        bus.fm_done   = 1'b0;
        bus.fx_data   = $urandom;
        bus.fs_data   = $urandom;
        bus.duty_data = $urandom;
    endtask

    // Counts clear and gate cycles; optionally injects a command mid-gate.
    task automatic run_phases(input bit inject, input logic [31:0] icmd, input int at_gate,
                              output int clr_n, output int gate_n, output bit ok);
        clr_n = 0; gate_n = 0; ok = 0;
        for (int i = 0; i < 3000; i++) begin
            bus.cmd_valid = 1'b0;
            if (bus.fm_clear) clr_n++;
            if (bus.fm_gate) gate_n++;
            if (gate_n > 0 && !bus.fm_gate) begin
                ok = 1;
                break;
            end
            if (inject && bus.fm_gate && gate_n == at_gate) begin
                bus.cmd_in    = icmd;
                bus.cmd_valid = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.rsp_data !== 32'h0 || bus.es_cmd !== 32'h0 || bus.es_cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: rsp %h es_cmd %h es_v %b, required 0 0 0",
                     bus.rsp_data, bus.es_cmd, bus.es_cmd_valid);
        end
        n_checks++;
        if (bus.fm_clear !== 1'b0 || bus.fm_gate !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: clear %b gate %b busy %b, required 0 0 0",
                     bus.fm_clear, bus.fm_gate, bus.busy);
        end
    endtask

    task automatic test_status_read();
        send_cmd(32'h0000_0000);
        n_checks++;
        if (bus.es_cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL status_no_es: es_cmd_valid %b, required 0", bus.es_cmd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.rsp_data !== exp_status() || bus.es_cmd_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL status_read: rsp %h es_v %b, required %h 0",
                     bus.rsp_data, bus.es_cmd_valid, exp_status());
        end
    endtask

    task automatic test_es_forward();
        logic [31:0] c, d;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                c = 32'h2000_1234; d = 32'hCAFE_BABE;
            end else begin
                c = {4'($urandom_range(1, 3)), 28'($urandom)}; d = $urandom;
            end
            bus.es_data = d;
            send_cmd(c);
            n_checks++;
            if (bus.es_cmd !== c || bus.es_cmd_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL es_fwd[%0d]: es_cmd %h v %b, required %h 1",
                         i, bus.es_cmd, bus.es_cmd_valid, c);
            end
            @(negedge clk);
            n_checks++;
            if (bus.es_cmd_valid !== 1'b0 || bus.rsp_data !== d) begin
                n_errors++;
                $display("FAIL es_readback[%0d]: v %b rsp %h, required 0 %h",
                         i, bus.es_cmd_valid, bus.rsp_data, d);
            end
            d = $urandom;
            bus.es_data = d;
            @(negedge clk);
            n_checks++;
            if (bus.rsp_data !== d) begin
                n_errors++;
                $display("FAIL es_live[%0d]: rsp %h, required %h", i, bus.rsp_data, d);
            end
        end
    endtask

    task automatic test_measure();
        int          n, cn, gn;
        bit          ok;
        logic [31:0] fx, fs, du, v;
        for (int it = 0; it < 2; it++) begin
            n = (it == 0) ? 3 : int'($urandom_range(1, 4));
            send_cmd(32'h4000_0000 | 32'(n));
            m_done = 0;
            run_phases(1'b0, 32'h0, 0, cn, gn, ok);
            n_checks++;
            if (!ok || cn != C || gn != n * G) begin
                n_errors++;
                $display("FAIL meas_phases[%0d]: ok %0d clear %0d gate %0d, required 1 %0d %0d",
                         it, ok, cn, gn, C, n * G);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if (it == 0) begin
                fx = 1000; fs = 50000; du = 25000;
            end else begin
                fx = $urandom; fs = $urandom; du = $urandom;
            end
            pulse_done(fx, fs, du);
            m_fx = fx; m_fs = fs; m_duty = du;
            m_done = 1; m_cnt = m_cnt + 16'd1; m_state = 4;
            read_sel(4'h5, v);
            n_checks++;
            if (v !== m_fx) begin
                n_errors++;
                $display("FAIL meas_fx[%0d]: %h, required %h", it, v, m_fx);
            end
            read_sel(4'h6, v);
            n_checks++;
            if (v !== m_fs) begin
                n_errors++;
                $display("FAIL meas_fs[%0d]: %h, required %h", it, v, m_fs);
            end
            read_sel(4'h7, v);
            n_checks++;
            if (v !== m_duty) begin
                n_errors++;
                $display("FAIL meas_duty[%0d]: %h, required %h", it, v, m_duty);
            end
            read_sel(4'h0, v);
            n_checks++;
            if (v !== exp_status()) begin
                n_errors++;
                $display("FAIL meas_status[%0d]: %h, required %h", it, v, exp_status());
            end
        end
        // fm_done outside WAIT must not touch the latches
        pulse_done($urandom, $urandom, $urandom);
        read_sel(4'h5, v);
        n_checks++;
        if (v !== m_fx) begin
            n_errors++;
            $display("FAIL done_ignored: fx %h, required %h", v, m_fx);
        end
    endtask

    task automatic test_start_zero_busy();
        int          cn, gn;
        bit          ok;
        logic [31:0] v;
        send_cmd(32'h4000_0000);
        m_done = 0;
        run_phases(1'b1, 32'h4000_0005, 3, cn, gn, ok);
        m_eb = 1;
        n_checks++;
        if (!ok || cn != C || gn != G) begin
            n_errors++;
            $display("FAIL start_zero: ok %0d clear %0d gate %0d, required 1 %0d %0d",
                     ok, cn, gn, C, G);
        end
        pulse_done(32'd7, 32'd8, 32'd9);
        m_fx = 7; m_fs = 8; m_duty = 9; m_done = 1; m_cnt = m_cnt + 16'd1; m_state = 4;
        read_sel(4'h0, v);
        n_checks++;
        if (v !== exp_status()) begin
            n_errors++;
            $display("FAIL busy_status: %h, required %h", v, exp_status());
        end
    endtask

    task automatic test_timeout();
        int          cn, gn, k;
        bit          ok;
        logic [31:0] v;
        send_cmd(32'h0000_0000);
        send_cmd(32'h4000_0001);
        m_done = 0;
        run_phases(1'b0, 32'h0, 0, cn, gn, ok);
        k = 0;
        while (bus.rsp_data[31:29] !== 3'd4 && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (!ok || gn != G || k != T + 1) begin
            n_errors++;
            $display("FAIL timeout_delay: ok %0d gate %0d cycles %0d, required 1 %0d %0d",
                     ok, gn, k, G, T + 1);
        end
        m_state = 4; m_et = 1;
        n_checks++;
        if (bus.rsp_data !== exp_status()) begin
            n_errors++;
            $display("FAIL timeout_status: %h, required %h", bus.rsp_data, exp_status());
        end
        read_sel(4'h5, v);
        n_checks++;
        if (v !== m_fx) begin
            n_errors++;
            $display("FAIL timeout_retain: fx %h, required %h", v, m_fx);
        end
        send_cmd(32'h9000_0000);
        m_eb = 0; m_ei = 0; m_et = 0;
        read_sel(4'h0, v);
        n_checks++;
        if (v !== exp_status()) begin
            n_errors++;
            $display("FAIL err_clear: %h, required %h", v, exp_status());
        end
    endtask

    task automatic test_illegal_abort();
        int          cn, gn;
        bit          ok;
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) send_cmd(32'hF000_0000);
            else send_cmd({4'($urandom_range(10, 15)), 28'($urandom)});
            m_ei = 1;
            read_sel(4'h0, v);
            n_checks++;
            if (v !== exp_status()) begin
                n_errors++;
                $display("FAIL illegal[%0d]: %h, required %h", i, v, exp_status());
            end
        end
        send_cmd(32'h4000_0002);
        m_done = 0;
        run_phases(1'b1, 32'h8000_0000, 3, cn, gn, ok);
        n_checks++;
        if (!ok || gn != 3 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort: ok %0d gate %0d busy %b, required 1 3 0", ok, gn, bus.busy);
        end
        m_state = 0;
        read_sel(4'h0, v);
        n_checks++;
        if (v !== exp_status()) begin
            n_errors++;
            $display("FAIL abort_status: %h, required %h", v, exp_status());
        end
    endtask

    task automatic test_async_reset();
        int          k;
        logic [31:0] v;
        send_cmd(32'h4000_0002);
        k = 0;
        while (bus.fm_gate !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #2 rest = 1'b0;
        #1;
        n_checks++;
        if (k >= 100 || bus.fm_gate !== 1'b0 || bus.fm_clear !== 1'b0 || bus.busy !== 1'b0
            || bus.rsp_data !== 32'h0) begin
            n_errors++;
            $display("FAIL async_reset: wait %0d gate %b clear %b busy %b rsp %h, required 0s",
                     k, bus.fm_gate, bus.fm_clear, bus.busy, bus.rsp_data);
        end
        @(negedge clk);
        rest = 1'b1;
        model_reset();
        read_sel(4'h0, v);
        n_checks++;
        if (v !== exp_status()) begin
            n_errors++;
            $display("FAIL post_reset_status: %h, required %h", v, exp_status());
        end
    endtask

    initial begin
        rest          = 1'b0;
        bus.cmd_in    = '0;
        bus.cmd_valid = 1'b0;
        bus.es_data   = '0;
        bus.fm_done   = 1'b0;
        bus.fx_data   = '0;
        bus.fs_data   = '0;
        bus.duty_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rest = 1'b1;
        @(negedge clk);
        test_status_read();
        test_es_forward();
        test_measure();
        test_start_zero_busy();
        test_timeout();
        test_illegal_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
